ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Parametrised control-word pipeline behind the main/ALU decoders: carries a CTRL_W-bit decoded
//  control bundle plus valid bit through NUM_STAGES registered stages (stage 0 = E, last = W).
//  Adds per-stage stall/flush, bubble insertion, a multi-cycle hold counter for M-extension ops
//  and full RV32 branch resolution (beq/bne/blt/bge/bltu/bgeu) from comparator flags in E.
// PARAMETERS
//  CTRL_W      16  width of decoded control word per stage
//  NUM_STAGES  3   registered stages after decode (>=2); stage 0 is Execute
//  MC_LAT      4   total cycles a multi-cycle op occupies stage 0 (>=1; 1 = no extra hold)
// PORTS
//  clk_i          in   1                    clock, all state on rising edge
//  rst_i          in   1                    synchronous reset, active-high
//  ctrl_d_i       in   CTRL_W               decoded control word from D
//  valid_d_i      in   1                    D holds a real instruction
//  branch_d_i     in   1                    D instruction is a conditional branch
//  jump_d_i       in   1                    D instruction is jal/jalr
//  mc_d_i         in   1                    D instruction is multi-cycle (mul/div)
//  funct3_d_i     in   3                    branch condition code
//  stall_i        in   NUM_STAGES           per-stage hold request
//  flush_i        in   NUM_STAGES           per-stage clear request
//  eq_e_i         in   1                    rs1==rs2 in E
//  lt_e_i         in   1                    signed rs1<rs2 in E
//  ltu_e_i        in   1                    unsigned rs1<rs2 in E
//  ctrl_o         out  NUM_STAGES*CTRL_W    stage k word at [k*CTRL_W +: CTRL_W]
//  valid_o        out  NUM_STAGES           stage valid bits
//  stall_d_o      out  1                    D must hold (= hold[0])
//  mc_busy_o      out  1                    multi-cycle op still occupying stage 0
//  pc_src_e_o     out  1                    redirect PC to target this cycle
// BEHAVIOUR
//  - Reset: all ctrl words 0, valid_o 0, branch/jump/mc/funct3 stage-0 copies 0, mc_cnt 0;
//    stall_d_o, mc_busy_o, pc_src_e_o therefore 0. Reset overrides every other input.
//  - hold[N-1] = stall_i[N-1]; hold[k] = stall_i[k] | hold[k+1]; hold[0] also ORs mc_busy_o.
//  - Stage k update, priority order: flush_i[k] -> valid 0, word 0; hold[k] -> keep;
//    k>0 and hold[k-1] -> bubble (valid 0, word 0); else load stage k-1 (stage 0 loads D inputs,
//    valid = valid_d_i). Bubble words are all-zero so no write/branch side effects downstream.
//  - Flush beats stall in the same stage; a flushed stage still holds upstream if hold[k] set.
//  - Multi-cycle: mc_busy_o = (mc_cnt != 0). When stage 0 loads a valid instruction with
//    mc_d_i=1 and MC_LAT>1, mc_cnt <= MC_LAT-1. While nonzero, mc_cnt decrements every cycle
//    regardless of stall_i (unit keeps running). flush_i[0] forces mc_cnt <= 0.
//    Net effect: op sits in stage 0 exactly MC_LAT cycles absent other stalls.
//  - Branch condition on stage-0 funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu,
//    010/011 never taken.
//  - pc_src_e_o (comb) = valid_o[0] & ~hold[0] & ~flush_i[0] & (jump0 | branch0 & cond);
//    fires exactly once per taken branch/jump, on the cycle it leaves stage 0.
//  - Latency: D word appears on stage k output k+1 cycles after capture with no stalls.
// TESTING
//  1. Reset then valid_d_i=1, ctrl_d_i=16'hA5A5 one cycle -> stage0=A5A5 @+1, stage1 @+2, stage2 @+3;
//     valid_o walks 001,010,100,000.
//  2. Branch funct3=101, lt_e_i=0 -> pc_src_e_o=1; lt_e_i=1 -> 0; funct3=010, eq=1 -> 0.
//  3. stall_i=3'b010 for 2 cycles with full pipe -> stages 0,1 frozen, stage 2 gets bubble
//     (valid 0, word 0), stall_d_o=1; taken branch in stage 0 holds pc_src_e_o=0 until release.
//  4. mc_d_i=1, MC_LAT=4 -> mc_busy_o=1 for 3 cycles after load, stage 0 held 4 cycles total,
//     stage 1 receives 3 bubbles then the op.
//  5. flush_i=3'b001 during mc_busy with taken jump in stage 0 -> pc_src_e_o=0, mc_cnt=0,
//     valid_o[0]=0 next cycle; flush_i[1]&stall_i[1] same cycle -> stage 1 cleared.
//  6. rst_i asserted mid multi-cycle op with full pipe -> next cycle all outputs 0.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Control-word pipeline from decode through NUM_STAGES registered stages (stage 0 = Execute).
// Handles per-stage stall/flush, bubble insertion, multi-cycle hold and branch resolution in E.
module ctrl_pipe_unit #(
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MC_LAT     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CTRL_W-1:0]            ctrl_d_i,
  input  logic                         valid_d_i,
  input  logic                         branch_d_i,
  input  logic                         jump_d_i,
  input  logic                         mc_d_i,
  input  logic [2:0]                   funct3_d_i,
  input  logic [NUM_STAGES-1:0]        stall_i,
  input  logic [NUM_STAGES-1:0]        flush_i,
  input  logic                         eq_e_i,
  input  logic                         lt_e_i,
  input  logic                         ltu_e_i,
  output logic [NUM_STAGES*CTRL_W-1:0] ctrl_o,
  output logic [NUM_STAGES-1:0]        valid_o,
  output logic                         stall_d_o,
  output logic                         mc_busy_o,
  output logic                         pc_src_e_o
);

  localparam int unsigned CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] MC_RELOAD = CNT_W'(MC_LAT - 1);
  localparam bit MC_EN = (MC_LAT > 1);

  logic [CTRL_W-1:0]     r_ctrl [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_valid;
  logic                  r_branch0;
  logic                  r_jump0;
  logic [2:0]            r_funct3_0;
  logic [CNT_W-1:0]      r_mc_cnt;

  logic                  w_mc_busy;
  logic [NUM_STAGES-1:0] w_hold;
  logic                  w_load0;
  logic                  w_mc_start;
  logic                  w_cond;

  assign w_mc_busy = (r_mc_cnt != '0);

  // A stage holds if it or anything downstream stalls; stage 0 also holds while the MC unit runs.
  always_comb begin
    logic v_any;
    w_hold = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      v_any = 1'b0;
      for (int j = k; j < int'(NUM_STAGES); j++) begin
        v_any = v_any | stall_i[j];
      end
      w_hold[k] = v_any;
    end
    w_hold[0] = w_hold[0] | w_mc_busy;
  end

  assign w_load0    = ~flush_i[0] & ~w_hold[0];
  assign w_mc_start = MC_EN & w_load0 & valid_d_i & mc_d_i;

  // RV32 conditional-branch evaluation on the stage-0 condition code
  always_comb begin
    w_cond = 1'b0;
    case (r_funct3_0)
      3'b000:  w_cond = eq_e_i;
      3'b001:  w_cond = ~eq_e_i;
      3'b100:  w_cond = lt_e_i;
      3'b101:  w_cond = ~lt_e_i;
      3'b110:  w_cond = ltu_e_i;
      3'b111:  w_cond = ~ltu_e_i;
      default: w_cond = 1'b0;
    endcase
  end

  // Stage 0: captures the decode-side bundle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl[0]  <= '0;
      r_valid[0] <= 1'b0;
      r_branch0  <= 1'b0;
      r_jump0    <= 1'b0;
      r_funct3_0 <= 3'b000;
    end else if (flush_i[0]) begin
      r_ctrl[0]  <= '0;
      r_valid[0] <= 1'b0;
      r_branch0  <= 1'b0;
      r_jump0    <= 1'b0;
      r_funct3_0 <= 3'b000;
    end else if (!w_hold[0]) begin
      r_ctrl[0]  <= ctrl_d_i;
      r_valid[0] <= valid_d_i;
      r_branch0  <= branch_d_i;
      r_jump0    <= jump_d_i;
      r_funct3_0 <= funct3_d_i;
    end
  end

  // Stages 1..N-1: flush, hold, bubble behind a held upstream stage, or advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        r_ctrl[k]  <= '0;
        r_valid[k] <= 1'b0;
      end
    end else begin
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        if (flush_i[k]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
        end else if (w_hold[k]) begin
          r_ctrl[k]  <= r_ctrl[k];
          r_valid[k] <= r_valid[k];
        end else if (w_hold[k-1]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
        end else begin
          r_ctrl[k]  <= r_ctrl[k-1];
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  end

  // Multi-cycle counter keeps running through stalls; only reset or a stage-0 flush stops it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mc_cnt <= '0;
    end else if (flush_i[0]) begin
      r_mc_cnt <= '0;
    end else if (w_mc_start) begin
      r_mc_cnt <= MC_RELOAD;
    end else if (w_mc_busy) begin
      r_mc_cnt <= r_mc_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      ctrl_o[k*CTRL_W +: CTRL_W] = r_ctrl[k];
    end
  end

  assign valid_o    = r_valid;
  assign stall_d_o  = w_hold[0];
  assign mc_busy_o  = w_mc_busy;
  assign pc_src_e_o = r_valid[0] & ~w_hold[0] & ~flush_i[0] & (r_jump0 | (r_branch0 & w_cond));

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Randomized bench for ctrl_pipe_unit against a cycle-level behavioural model of the pipeline.
module tb_ctrl_pipe_unit;

  localparam int unsigned CW = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned ML = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [CW-1:0]   ctrl_d_i;
  logic            valid_d_i, branch_d_i, jump_d_i, mc_d_i;
  logic [2:0]      funct3_d_i;
  logic [NS-1:0]   stall_i, flush_i;
  logic            eq_e_i, lt_e_i, ltu_e_i;
  logic [NS*CW-1:0] ctrl_o;
  logic [NS-1:0]   valid_o;
  logic            stall_d_o, mc_busy_o, pc_src_e_o;

  ctrl_pipe_unit #(.CTRL_W(CW), .NUM_STAGES(NS), .MC_LAT(ML)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_d_i(ctrl_d_i), .valid_d_i(valid_d_i),
    .branch_d_i(branch_d_i), .jump_d_i(jump_d_i), .mc_d_i(mc_d_i), .funct3_d_i(funct3_d_i),
    .stall_i(stall_i), .flush_i(flush_i), .eq_e_i(eq_e_i), .lt_e_i(lt_e_i), .ltu_e_i(ltu_e_i),
    .ctrl_o(ctrl_o), .valid_o(valid_o), .stall_d_o(stall_d_o), .mc_busy_o(mc_busy_o),
    .pc_src_e_o(pc_src_e_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-stage contents plus remaining multi-cycle occupancy
  logic [CW-1:0] m_ctrl [NS];
  bit            m_valid [NS];
  bit            m_br, m_jp;
  int            m_f3;
  int            m_rem;

  function automatic bit taken(int f3, bit eq, bit lt, bit ltu);
    case (f3)
      0: return eq;
      1: return !eq;
      4: return lt;
      5: return !lt;
      6: return ltu;
      7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit hold_at(int k);
    return ((int'(stall_i) >> k) != 0) || (k == 0 && m_rem > 0);
  endfunction

  task automatic compare_outputs();
    logic [NS*CW-1:0] e_ctrl;
    logic [NS-1:0]    e_valid;
    bit               e_pc;
    for (int k = 0; k < int'(NS); k++) begin
      e_ctrl[k*CW +: CW] = m_ctrl[k];
      e_valid[k]         = m_valid[k];
    end
    e_pc = m_valid[0] && !hold_at(0) && !flush_i[0] &&
           (m_jp || (m_br && taken(m_f3, eq_e_i, lt_e_i, ltu_e_i)));
    check_eq("ctrl_o", 64'(ctrl_o), 64'(e_ctrl));
    check_eq("valid_o", 64'(valid_o), 64'(e_valid));
    check_eq("stall_d_o", 64'(stall_d_o), 64'(hold_at(0)));
    check_eq("mc_busy_o", 64'(mc_busy_o), 64'(m_rem > 0));
    check_eq("pc_src_e_o", 64'(pc_src_e_o), 64'(e_pc));
  endtask

  task automatic model_step();
    bit h [NS];
    if (rst_i) begin
      for (int k = 0; k < int'(NS); k++) begin
        m_ctrl[k] = '0;
        m_valid[k] = 1'b0;
      end
      m_br = 0; m_jp = 0; m_f3 = 0; m_rem = 0;
      return;
    end
    for (int k = 0; k < int'(NS); k++) h[k] = hold_at(k);
    for (int k = int'(NS) - 1; k >= 0; k--) begin
      if (flush_i[k] || (!h[k] && k > 0 && h[k-1])) begin
        m_ctrl[k] = '0;
        m_valid[k] = 1'b0;
      end else if (!h[k]) begin
        m_ctrl[k]  = (k == 0) ? ctrl_d_i : m_ctrl[k-1];
        m_valid[k] = (k == 0) ? valid_d_i : m_valid[k-1];
      end
    end
    if (flush_i[0]) begin
      m_br = 0; m_jp = 0; m_f3 = 0;
    end else if (!h[0]) begin
      m_br = branch_d_i; m_jp = jump_d_i; m_f3 = int'(funct3_d_i);
    end
    if (flush_i[0]) m_rem = 0;
    else if (!h[0] && valid_d_i && mc_d_i && ML > 1) m_rem = int'(ML) - 1;
    else if (m_rem > 0) m_rem--;
  endtask

  task automatic tick_and_check();
    #1 compare_outputs();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic drive_idle();
    rst_i = 0; ctrl_d_i = '0; valid_d_i = 0; branch_d_i = 0; jump_d_i = 0; mc_d_i = 0;
    funct3_d_i = 3'b000; stall_i = '0; flush_i = '0; eq_e_i = 0; lt_e_i = 0; ltu_e_i = 0;
  endtask

  task automatic drive_random();
    rst_i      = ($urandom_range(0, 79) == 0);
    ctrl_d_i   = CW'($urandom);
    valid_d_i  = ($urandom_range(0, 3) != 0);
    branch_d_i = ($urandom_range(0, 2) == 0);
    jump_d_i   = !branch_d_i && ($urandom_range(0, 5) == 0);
    mc_d_i     = ($urandom_range(0, 5) == 0);
    funct3_d_i = 3'($urandom);
    for (int k = 0; k < int'(NS); k++) begin
      stall_i[k] = ($urandom_range(0, 5) == 0);
      flush_i[k] = ($urandom_range(0, 11) == 0);
    end
    eq_e_i  = 1'($urandom);
    lt_e_i  = 1'($urandom);
    ltu_e_i = 1'($urandom);
  endtask

  logic [NS-1:0] walk [4];

  initial begin
    walk[0] = 3'b001; walk[1] = 3'b010; walk[2] = 3'b100; walk[3] = 3'b000;
    drive_idle();
    rst_i = 1;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    rst_i = 1;
    tick_and_check();

    // Single word walking down the pipe
    drive_idle();
    valid_d_i = 1; ctrl_d_i = 16'hA5A5;
    tick_and_check();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("walk_valid", 64'(valid_o), 64'(walk[i]));
      if (i < 3) check_eq("walk_word", 64'(ctrl_o[i*CW +: CW]), 64'h0000_0000_0000_A5A5);
      tick_and_check();
    end

    // Branch bge taken/not taken, then funct3=010 never taken
    valid_d_i = 1; branch_d_i = 1; funct3_d_i = 3'b101;
    tick_and_check();
    drive_idle();
    lt_e_i = 0;
    #1 check_eq("bge_taken", 64'(pc_src_e_o), 64'd1);
    lt_e_i = 1;
    #1 check_eq("bge_not_taken", 64'(pc_src_e_o), 64'd0);
    valid_d_i = 1; branch_d_i = 1; funct3_d_i = 3'b010; eq_e_i = 1;
    tick_and_check();
    drive_idle();
    eq_e_i = 1;
    #1 check_eq("f3_010_never", 64'(pc_src_e_o), 64'd0);
    tick_and_check();

    // Multi-cycle op: busy three cycles, stage 1 gets bubbles then the op
    valid_d_i = 1; mc_d_i = 1; ctrl_d_i = 16'h1234;
    tick_and_check();
    drive_idle();
    valid_d_i = 1; ctrl_d_i = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("mc_busy", 64'(mc_busy_o), 64'd1);
      check_eq("mc_stage0", 64'(ctrl_o[CW-1:0]), 64'h1234);
      tick_and_check();
    end
    #1 check_eq("mc_done", 64'(mc_busy_o), 64'd0);
    tick_and_check();
    #1 check_eq("mc_stage1", 64'(ctrl_o[2*CW-1:CW]), 64'h1234);
    drive_idle();
    tick_and_check();

    // Flush during busy multi-cycle jump; also flush beats stall in stage 1
    valid_d_i = 1; mc_d_i = 1; jump_d_i = 1; ctrl_d_i = 16'hBEEF;
    tick_and_check();
    drive_idle();
    flush_i = 3'b011; stall_i = 3'b010;
    #1 check_eq("flush_pc", 64'(pc_src_e_o), 64'd0);
    tick_and_check();
    drive_idle();
    #1 check_eq("flush_busy", 64'(mc_busy_o), 64'd0);
    check_eq("flush_valid", 64'(valid_o[1:0]), 64'd0);
    tick_and_check();

    // Reset mid multi-cycle op with a full pipe
    for (int i = 0; i < 3; i++) begin
      valid_d_i = 1; ctrl_d_i = CW'($urandom); mc_d_i = (i == 2);
      tick_and_check();
    end
    drive_idle();
    rst_i = 1;
    tick_and_check();
    drive_idle();
    #1 check_eq("rst_ctrl", 64'(ctrl_o), 64'd0);
    check_eq("rst_misc", 64'({valid_o, stall_d_o, mc_busy_o, pc_src_e_o}), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick_and_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
